mmio_responder: RTL and testbench
=================================

// Module: mmio_responder
// PURPOSE
//   Memory-mapped I/O target for the CPU's data-side load/store port: it answers
//   accesses with addr[31]==1.
//   Buffers one UART RX byte and one UART TX byte behind the on-chip UART
//   ready/valid interface.
//   Maintains the cycle and retired-instruction counters for the core's
//   performance reporting.
//   Read data has the same 1-cycle synchronous latency as dmem, so the MW-stage
//   load mux treats both identically.
// PARAMETERS
//   CNT_W      32   width of cycle/instruction counters (<=32, zero-extended on read)
// PORTS
//   clk          in   1   core clock
//   rst          in   1   synchronous reset, active-low (0 = reset, sampled on posedge clk)
//   req_en       in   1   access valid this cycle
//   req_addr     in   32  byte address; responder acts only when req_addr[31]==1
//   req_we       in   4   byte write enables; 4'b0000 = read, nonzero = write
//   req_wdata    in   32  write data
//   rdata        out  32  read data, valid the cycle after a read request
//   rx_data      in   8   byte from UART receiver
//   rx_valid     in   1   rx_data valid
//   rx_ready     out  1   responder can accept rx_data
//   tx_data      out  8   byte to UART transmitter
//   tx_valid     out  1   tx_data valid
//   tx_ready     in   1   transmitter accepts tx_data
//   inst_retire  in   1   one instruction retired this cycle
// BEHAVIOUR
//   Address map (offset = req_addr[7:0], hit = req_en & req_addr[31]):
//     0x00 RO  UART ctrl: {30'b0, rx_full, ~tx_full}
//     0x04 RO  UART rx:   {24'b0, rx_buf}; read pops the RX buffer
//     0x08 WO  UART tx:   req_wdata[7:0]; pushes the TX buffer; takes effect only if req_we[0]
//     0x10 RO  cycle counter, zero-extended
//     0x14 RO  instruction counter, zero-extended
//     0x18 WO  counter reset; any write clears both counters
//   Reset (rst==0): rdata=0, tx_valid=0, tx_data=0, rx_ready=0,
//     rx_full=0, tx_full=0, both counters=0.
//   Reads:
//     - rdata is registered: the value for a read in cycle N appears in cycle N+1.
//     - rdata holds its last value when there is no read hit.
//     - Unmapped or WO offsets read as 0.
//     - Reads of 0x04 while RX is empty return 0 and have no side effect.
//   Writes: writes to RO or unmapped offsets are ignored.
//     Non-hit accesses (addr[31]==0 or req_en==0) have no effect.
//   RX buffer (1 entry):
//     - rx_ready = ~rx_full (0 during reset).
//     - rx_valid & rx_ready captures rx_data into rx_buf and sets rx_full.
//     - A read of 0x04 while full returns rx_buf and clears rx_full in the same edge.
//     - rx_ready is therefore 1 again in cycle N+1.
//     - No capture occurs while full: the byte stays held in the UART.
//   TX buffer (1 entry):
//     - tx_valid = tx_full and tx_data = tx_buf.
//     - A write to 0x08 with tx_full==0 loads tx_buf and sets tx_full.
//     - A write to 0x08 with tx_full==1 is dropped; software must poll ctrl bit0.
//     - tx_valid & tx_ready clears tx_full.
//     - A new write in the same cycle as the handshake is dropped, because the
//       full check uses the pre-edge tx_full.
//   Counters:
//     - cycle_cnt increments every cycle out of reset.
//     - inst_cnt increments when inst_retire==1.
//     - Both wrap modulo 2^CNT_W.
//     - A counter-reset write forces both to 0 on that edge and overrides the
//       increment.
//     - Counting resumes on the next cycle.
//   Reset mid-operation: a pending RX byte, TX byte and counters are discarded.
//     A read issued in the cycle rst==0 yields rdata=0.
// TESTING
//   1. Release rst, idle 10 cycles, read 0x10 -> rdata == 10 +/- decode offset,
//      checked against a bench cycle model, one cycle after the request.
//   2. Drive rx_valid with 8'h41 -> rx_ready drops. Read 0x00 -> 32'h3.
//      Read 0x04 -> 32'h41 and rx_ready==1 the next cycle. Read 0x00 -> 32'h1.
//   3. Hold tx_ready=0 and write 0x08 data 32'h5A -> tx_valid=1, tx_data=8'h5A.
//      Write 32'h33 -> dropped. Raise tx_ready -> tx_valid=0 next cycle and
//      ctrl bit0=1.
//   4. Pulse inst_retire 7 times, then write 0x18 in the same cycle as an
//      inst_retire -> 0x14 reads 0, then reads 1 after one further retire.
//   5. Write 0x08 with addr[31]=0, and read 0x0C -> no tx_valid, rdata=0.
//      Assert rst=0 with a TX byte pending -> tx_valid=0 and counters=0.

Source files
------------

// File: rtl/mmio_responder.sv
// mmio_responder: memory-mapped target for the data-side load/store port.
// It answers accesses with req_addr[31]==1. Behind the address map it holds
// a one-byte UART RX buffer, a one-byte UART TX buffer, and the cycle and
// retired-instruction counters. Read data is registered, so it has the same
// one-cycle latency as dmem.
//
// Both UART sides use strict valid/ready handshakes. A byte transfers on a
// rising clk edge where valid and ready are both 1. valid must not depend on
// ready, and the data is held stable while valid is 1 and ready is 0. Here
// rx_ready is ~rx_full, forced to 0 while rst is low. tx_valid is tx_full.
module mmio_responder #(
   parameter int CNT_W = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_en,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_we,
   input  logic [31:0] req_wdata,
   output logic [31:0] rdata,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic        inst_retire
);

   localparam logic [7:0] OFF_CTRL = 8'h00;
   localparam logic [7:0] OFF_RX   = 8'h04;
   localparam logic [7:0] OFF_TX   = 8'h08;
   localparam logic [7:0] OFF_CYC  = 8'h10;
   localparam logic [7:0] OFF_INST = 8'h14;
   localparam logic [7:0] OFF_CCLR = 8'h18;

   logic             rx_full;
   logic [7:0]       rx_buf;
   logic             tx_full;
   logic [7:0]       tx_buf;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] inst_cnt;

   logic [7:0]  offset;
   logic        rd_hit;
   logic        wr_hit;
   logic [31:0] rd_val;
   logic        rx_cap;
   logic        rx_pop;
   logic        tx_push;
   logic        tx_pop;
   logic        cnt_clr;

   // Only the low address byte is decoded, and only tx data bits [7:0] are used.
   logic unused_bits;
   assign unused_bits = ^{req_addr[30:8], req_wdata[31:8]};

   assign rx_ready = rst & ~rx_full;
   assign tx_valid = tx_full;
   assign tx_data  = tx_buf;

   // Decode the access and derive the buffer and counter events from the pre-edge state.
   always_comb begin
      offset  = req_addr[7:0];
      rd_hit  = req_en & req_addr[31] & (req_we == 4'b0000);
      wr_hit  = req_en & req_addr[31] & (req_we != 4'b0000);
      rx_cap  = rx_valid & ~rx_full;
      rx_pop  = rd_hit & (offset == OFF_RX) & rx_full;
      tx_push = wr_hit & (offset == OFF_TX) & req_we[0] & ~tx_full;
      tx_pop  = tx_full & tx_ready;
      cnt_clr = wr_hit & (offset == OFF_CCLR);
      rd_val  = 32'h0;
      case (offset)
         OFF_CTRL: rd_val = {30'h0, rx_full, ~tx_full};
         OFF_RX:   rd_val = rx_full ? {24'h0, rx_buf} : 32'h0;
         OFF_CYC:  rd_val = 32'(cycle_cnt);
         OFF_INST: rd_val = 32'(inst_cnt);
         default:  rd_val = 32'h0;
      endcase
   end

   // Register read data, the buffers and the counters. Reset discards everything.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rdata     <= 32'h0;
         rx_full   <= 1'b0;
         rx_buf    <= 8'h0;
         tx_full   <= 1'b0;
         tx_buf    <= 8'h0;
         cycle_cnt <= '0;
         inst_cnt  <= '0;
      end else begin
         if (rd_hit) begin
            rdata <= rd_val;
         end
         if (rx_cap) begin
            rx_buf  <= rx_data;
            rx_full <= 1'b1;
         end else if (rx_pop) begin
            rx_full <= 1'b0;
         end
         if (tx_push) begin
            tx_buf  <= req_wdata[7:0];
            tx_full <= 1'b1;
         end else if (tx_pop) begin
            tx_full <= 1'b0;
         end
         if (cnt_clr) begin
            cycle_cnt <= '0;
            inst_cnt  <= '0;
         end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            inst_cnt  <= inst_cnt + CNT_W'(inst_retire);
         end
      end
   end

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder. A transaction-level model predicts every output.
// It is compared each cycle, and directed literal checks pin the model.
module tb_mmio_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_en;
   logic [31:0] req_addr;
   logic [3:0]  req_we;
   logic [31:0] req_wdata;
   logic [31:0] rdata;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        inst_retire;

   int checks_total = 0;
   int checks_passed = 0;

   mmio_responder #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .req_en(req_en), .req_addr(req_addr),
      .req_we(req_we), .req_wdata(req_wdata), .rdata(rdata),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .inst_retire(inst_retire)
   );

   // clock / reset block
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks_total++;
      if (actual === expected) checks_passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
   endtask

   // Model state: the registers seen by software, plus the two byte buffers.
   bit          model_ready = 0;
   bit          m_rx_have, m_tx_have;
   logic [7:0]  m_rx_byte, m_tx_byte;
   logic [31:0] m_cycles, m_retired, m_rdata;
   logic [31:0] exp_q[$];

   function automatic logic [31:0] model_read(input logic [7:0] off);
      logic [31:0] v;
      v = 32'h0;
      if (off == 8'h00) v = (m_rx_have ? 32'd2 : 32'd0) + (m_tx_have ? 32'd0 : 32'd1);
      if (off == 8'h04 && m_rx_have) v = 32'(m_rx_byte);
      if (off == 8'h10) v = m_cycles;
      if (off == 8'h14) v = m_retired;
      return v;
   endfunction

   // Model: apply one clock edge of the bus and UART traffic to the software-visible state.
   always @(posedge clk) begin
      bit is_read, is_write, was_rx, was_tx;
      logic [7:0] off;
      if (!rst) begin
         m_rx_have = 0; m_tx_have = 0; m_rx_byte = 0; m_tx_byte = 0;
         m_cycles = 0; m_retired = 0; m_rdata = 0;
      end else begin
         off      = req_addr[7:0];
         is_read  = req_en && req_addr[31] && req_we == 4'b0000;
         is_write = req_en && req_addr[31] && req_we != 4'b0000;
         was_rx   = m_rx_have;
         was_tx   = m_tx_have;
         if (is_read) m_rdata = model_read(off);
         if (is_read && off == 8'h04) m_rx_have = 0;
         if (!was_rx && rx_valid) begin m_rx_have = 1; m_rx_byte = rx_data; end
         if (was_tx && tx_ready) m_tx_have = 0;
         if (!was_tx && is_write && off == 8'h08 && req_we[0]) begin
            m_tx_have = 1; m_tx_byte = req_wdata[7:0];
         end
         if (is_write && off == 8'h18) begin
            m_cycles = 0; m_retired = 0;
         end else begin
            m_cycles  = m_cycles + 1;
            m_retired = m_retired + (inst_retire ? 1 : 0);
         end
      end
      model_ready = 1;
   end

   // Compare process: every output against the model, away from the active edge.
   always @(negedge clk) begin
      if (model_ready) begin
         check("rdata", rdata, m_rdata);
         check("tx_valid", 32'(tx_valid), 32'(m_tx_have));
         check("tx_data", 32'(tx_data), 32'(m_tx_byte));
         check("rx_ready", 32'(rx_ready), 32'(rst && !m_rx_have));
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
      req_en = 1; req_addr = addr; req_we = 4'b0000;
      step();
      req_en = 0;
      data = rdata;
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
      req_en = 1; req_addr = addr; req_we = we; req_wdata = data;
      step();
      req_en = 0; req_we = 4'b0000;
   endtask

   // Scoreboard for directed reads: expected values computed by hand.
   task automatic read_expect(input string name, input logic [31:0] addr);
      logic [31:0] got;
      bus_read(addr, got);
      check(name, got, exp_q.pop_front());
   endtask

   initial begin
      logic [31:0] d;
      rst = 0; req_en = 0; req_addr = 0; req_we = 0; req_wdata = 0;
      rx_data = 0; rx_valid = 0; tx_ready = 0; inst_retire = 0;
      repeat (3) step();
      check("reset_rdata", rdata, 32'h0);
      check("reset_tx_valid", 32'(tx_valid), 32'h0);
      check("reset_rx_ready", 32'(rx_ready), 32'h0);

      // 1. cycle counter after 10 idle cycles
      rst = 1;
      repeat (10) step();
      exp_q.push_back(32'd10);
      read_expect("cycle_after_10", 32'h8000_0010);

      // 2. RX path; the 8'h42 offered while full must not be captured
      rx_valid = 1; rx_data = 8'h41;
      step();
      rx_data = 8'h42;
      check("rx_ready_full", 32'(rx_ready), 32'h0);
      exp_q.push_back(32'h3);
      read_expect("ctrl_rx_full", 32'h8000_0000);
      exp_q.push_back(32'h41);
      read_expect("rx_pop", 32'h8000_0004);
      rx_valid = 0;
      check("rx_ready_after_pop", 32'(rx_ready), 32'h1);
      exp_q.push_back(32'h1);
      read_expect("ctrl_rx_empty", 32'h8000_0000);
      exp_q.push_back(32'h0);
      read_expect("rx_read_empty", 32'h8000_0004);

      // 3. TX path
      bus_write(32'h8000_0008, 32'h5A, 4'b1110);
      check("tx_we0_clear_ignored", 32'(tx_valid), 32'h0);
      bus_write(32'h8000_0008, 32'h5A, 4'b0001);
      check("tx_valid_set", 32'(tx_valid), 32'h1);
      check("tx_data_5a", 32'(tx_data), 32'h5A);
      bus_write(32'h8000_0008, 32'h33, 4'b1111);
      check("tx_drop_when_full", 32'(tx_data), 32'h5A);
      exp_q.push_back(32'h0);
      read_expect("ctrl_tx_full", 32'h8000_0000);
      tx_ready = 1;
      step();
      tx_ready = 0;
      check("tx_valid_cleared", 32'(tx_valid), 32'h0);
      exp_q.push_back(32'h1);
      read_expect("ctrl_tx_empty", 32'h8000_0000);

      // 4. retired-instruction counter and counter reset
      for (int i = 0; i < 7; i++) begin
         inst_retire = 1; step();
         inst_retire = 0; step();
      end
      exp_q.push_back(32'd7);
      read_expect("inst_7", 32'h8000_0014);
      inst_retire = 1;
      bus_write(32'h8000_0018, 32'h0, 4'b1111);
      inst_retire = 0;
      exp_q.push_back(32'd0);
      read_expect("inst_cleared", 32'h8000_0014);
      inst_retire = 1; step(); inst_retire = 0;
      exp_q.push_back(32'd1);
      read_expect("inst_after_one", 32'h8000_0014);

      // 5. non-hit write, unmapped and write-only reads, reset mid-operation
      bus_write(32'h0000_0008, 32'h77, 4'b0001);
      check("nonhit_no_tx", 32'(tx_valid), 32'h0);
      exp_q.push_back(32'h0);
      read_expect("unmapped_0c", 32'h8000_000C);
      exp_q.push_back(32'h0);
      read_expect("wo_08_reads_0", 32'h8000_0008);
      bus_write(32'h8000_0008, 32'h77, 4'b0001);
      rx_valid = 1; rx_data = 8'h99; step(); rx_valid = 0;
      check("tx_pending", 32'(tx_valid), 32'h1);
      rst = 0;
      bus_read(32'h8000_0010, d);
      check("read_in_reset", d, 32'h0);
      check("reset_drops_tx", 32'(tx_valid), 32'h0);
      rst = 1;
      exp_q.push_back(32'h1);
      read_expect("ctrl_after_reset", 32'h8000_0000);
      exp_q.push_back(32'h0);
      read_expect("inst_after_reset", 32'h8000_0014);

      repeat (3) step();
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
